// File: rtl/mem_pkg.sv
// Shared load-path definitions: op encodings (also used by EX decode) and bus
// width legality.
package mem_pkg;

   localparam int unsigned OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      LD_LB  = 3'b000,
      LD_LBU = 3'b001,
      LD_LH  = 3'b010,
      LD_LHU = 3'b011,
      LD_LW  = 3'b100
   } ld_op_e;

   // Per-entry bookkeeping carried from issue to write-back
   typedef struct packed {
      logic [OP_W-1:0] op;
      logic [4:0]      waddr;
      logic [31:0]     pc;
   } ld_req_t;

   function automatic bit data_w_legal(input int unsigned w);
      return (w == 32) || (w == 64);
   endfunction

endpackage

// File: rtl/load_align.sv
// Lane select and sign/zero extension of a load result from one bus beat.
// Purely combinational.
module load_align
   import mem_pkg::*;
#(
   parameter  int unsigned DATA_W = 32,
   localparam int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
   input  logic [OP_W-1:0]   op,
   input  logic [OFF_W-1:0]  off,
   input  logic [DATA_W-1:0] beat,
   output logic [31:0]       result_c
);

   logic [OFF_W-1:0]  half_off;
   logic [OFF_W-1:0]  word_off;
   logic [DATA_W-1:0] byte_sh;
   logic [DATA_W-1:0] half_sh;
   logic [DATA_W-1:0] word_sh;
   logic [7:0]        lb;
   logic [15:0]       lh;
   logic [31:0]       lw;

   // Low offset bits below the access size are ignored
   always_comb begin
      half_off = off & ~OFF_W'(1);
      word_off = off & ~OFF_W'(3);
      byte_sh  = beat >> {off, 3'b000};
      half_sh  = beat >> {half_off, 3'b000};
      word_sh  = beat >> {word_off, 3'b000};
      lb       = byte_sh[7:0];
      lh       = half_sh[15:0];
      lw       = word_sh[31:0];
   end

   always_comb begin
      result_c = '0;
      case (op)
         LD_LB:   result_c = {{24{lb[7]}}, lb};
         LD_LBU:  result_c = {24'd0, lb};
         LD_LH:   result_c = {{16{lh[15]}}, lh};
         LD_LHU:  result_c = {16'd0, lh};
         LD_LW:   result_c = lw;
         default: result_c = '0;
      endcase
   end

endmodule

// File: rtl/mem_load_queue.sv
// Outstanding-load queue: matches in-order bus read responses to issued loads,
// formats the data and hands it to WB through a registered valid/ready stage.
module mem_load_queue
   import mem_pkg::*;
#(
   parameter  int unsigned DATA_W = 32,
   parameter  int unsigned DEPTH  = 4,
   localparam int unsigned OFF_W  = $clog2(DATA_W / 8),
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [OP_W-1:0]   req_op,
   input  logic [OFF_W-1:0]  req_off,
   input  logic [4:0]        req_waddr,
   input  logic [31:0]       req_pc,
   input  logic              resp_valid,
   output logic              resp_ready,
   input  logic [DATA_W-1:0] resp_data,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [4:0]        wb_waddr,
   output logic [31:0]       wb_wdata,
   output logic [31:0]       wb_pc,
   output logic [CNT_W-1:0]  pending
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   if (!data_w_legal(DATA_W)) begin : g_bad_data_w
      $error("mem_load_queue: DATA_W must be 32 or 64");
   end
   if ((DEPTH < 2) || ((1 << PTR_W) != DEPTH)) begin : g_bad_depth
      $error("mem_load_queue: DEPTH must be a power of 2, at least 2");
   end

   ld_req_t           q_req [DEPTH];
   logic [OFF_W-1:0]  q_off [DEPTH];
   logic [DEPTH-1:0]  q_killed;
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count;
   logic              head_killed;
   logic              push;
   logic              pop;
   logic              load;
   logic [31:0]       align_c;

   always_comb begin
      head_killed = q_killed[head];
      req_ready   = (count < CNT_W'(DEPTH));
      resp_ready  = (count != '0) && (head_killed || !wb_valid || wb_ready);
      push        = req_valid && req_ready && !flush;
      pop         = resp_valid && resp_ready;
      load        = pop && !head_killed && !flush;
      pending     = count;
   end

   load_align #(.DATA_W(DATA_W)) u_align (
      .op       (q_req[head].op),
      .off      (q_off[head]),
      .beat     (resp_data),
      .result_c (align_c)
   );

   // Payload storage needs no reset: occupancy and killed bits qualify it
   always_ff @(posedge clk) begin
      if (push) begin
         q_req[tail] <= '{op: req_op, waddr: req_waddr, pc: req_pc};
         q_off[tail] <= req_off;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         q_killed <= '0;
         wb_valid <= 1'b0;
         wb_waddr <= '0;
         wb_wdata <= '0;
         wb_pc    <= '0;
      end else begin
         if (push) tail <= tail + PTR_W'(1);
         if (pop)  head <= head + PTR_W'(1);

         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase

         // Killing idle slots too is harmless: a push always re-arms its slot
         if (flush)     q_killed       <= '1;
         else if (push) q_killed[tail] <= 1'b0;

         if (flush) begin
            wb_valid <= 1'b0;
         end else if (load) begin
            wb_valid <= 1'b1;
            wb_waddr <= q_req[head].waddr;
            wb_pc    <= q_req[head].pc;
            wb_wdata <= align_c;
         end else if (wb_ready) begin
            wb_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/mem_load_queue.md
# mem_load_queue

Load-return stage for the AXI single-issue pipeline, successor to the fixed single-load MEM datapath. It tracks up to DEPTH outstanding loads issued by EX and matches in-order bus read responses to them. For each response it extracts and sign- or zero-extends the addressed byte, halfword or word from a DATA_W-wide bus beat, then presents the result to WB through a registered valid/ready output. On flush, all in-flight loads are discarded without losing bus synchronisation.

## Interface
- DATA_W, 32, read-data bus width in bits: 32 or 64.
- DEPTH, 4, maximum outstanding loads: a power of 2, at least 2.
- OFF_W, log2(DATA_W/8), derived width of the byte offset within a beat.
- clk  in  1  rising-edge clock. One clock only.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  exception or ERET flush from CP0. Kills every in-flight load.
- req_valid  in  1  EX issues a load this cycle.
- req_ready  out  1  queue can accept a load.
- req_op  in  3  load type: 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW. Any other code is illegal and its result is 0.
- req_off  in  OFF_W  byte offset of the load address within the bus beat.
- req_waddr  in  5  destination GPR.
- req_pc  in  32  PC of the load.
- resp_valid  in  1  bus returns read data. Responses arrive in request order.
- resp_ready  out  1  block accepts the response beat.
- resp_data  in  DATA_W  returned beat.
- wb_valid  out  1  a load result is available.
- wb_ready  in  1  WB consumes the result.
- wb_waddr  out  5  destination GPR of the result.
- wb_wdata  out  32  formatted load result.
- wb_pc  out  32  PC of the load.
- pending  out  log2(DEPTH)+1  number of occupied queue entries, including killed entries.

## Operation
- Circular queue of DEPTH entries, with head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH.
  - Each entry holds {op, off, waddr, pc, killed}.
  - The occupancy counter drives `pending`.
- Push: happens when req_valid && req_ready && !flush. The new entry is written at the tail with killed=0.
- req_ready = (pending < DEPTH). A pop in the same cycle does not bypass this, so a full queue cannot accept a request even if it is popping.
- resp_ready = (pending != 0) && (head.killed || !wb_valid || wb_ready).
- A response handshake always pops the head entry.
  - If head.killed, the beat is dropped.
  - Otherwise the formatted result loads the output register: wb_valid=1, plus waddr, pc and wdata.
- Formatting: the lane is selected by `off`, with low bits ignored per size.
  - Bytes use off.
  - Halfwords use off[OFF_W-1:1].
  - Words use off[OFF_W-1:2].
  - Alignment exceptions are raised upstream, not here.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
  - The lane is little-endian: byte k occupies resp_data[8k+7:8k].
- Output register:
  - Cleared (wb_valid=0) on wb_valid && wb_ready when no new result is loaded in the same cycle.
  - On a simultaneous consume and load, the new result replaces the old one. wb_valid stays 1.
- Flush:
  - Sets killed=1 on every occupied entry, including the head popping that cycle; its beat is dropped.
  - Clears wb_valid.
  - Suppresses any push in that cycle.
  - `pending` does not drop: killed entries drain only as their responses arrive.
- Protocol error: a response with pending==0 is never accepted, because resp_ready=0.

## Timing
- Reset (rst low, asynchronous):
  - Pointers, counter and all killed bits go to 0.
  - wb_valid=0, wb_waddr=0, wb_wdata=0, wb_pc=0, pending=0.
  - req_ready=1 and resp_ready=0 combinationally.
- Latency: from the response handshake at edge N, wb_valid is high after edge N. This is one cycle, with no combinational path from resp_data to wb_wdata.
- req_ready and resp_ready are combinational from registered state and wb_ready only. Neither depends on req_valid or resp_valid.
- With wb_ready held high, one result can be produced per cycle (full throughput).
- pending changes by +1 for a push only, -1 for a pop only, and 0 for both or neither.
- Reset asserted mid-operation discards all entries immediately. Responses still in flight on the bus afterwards are the bus bridge's responsibility.

## Structure
- Shared package `mem_pkg`: load op encodings (LD_LB..LD_LW), OP_W=3, and the DATA_W legality check.
- The op encodings are shared with the EX decode.
- Sub-module `load_align` is purely combinational: (op, off, beat) -> 32-bit result. It is parametrised by DATA_W and reused by the future store-merge path.
- Queue storage is a flop array, not a RAM macro, because killed bits need a parallel set.

## Test plan
- Single LB, DATA_W=32: off=3, resp_data=0x80_12_34_56 -> wb_wdata=0xFFFFFF80 one cycle after the handshake. With op LBU instead -> 0x00000080.
- DATA_W=64 LH: off=6, resp_data=0x8001_0000_0000_0000 -> 0xFFFF8001. LW with off=4 and the same beat -> 0x80010000.
- Fill DEPTH=4: four pushes then req_valid held -> req_ready=0 and pending=4. Then four responses with wb_ready=1 -> four results in order with waddr 1,2,3,4 and pending back to 0, exercising pointer wrap.
- Back-pressure: wb_ready=0 while two responses pending -> first result held, resp_ready=0, second beat stalls. Release wb_ready -> both delivered back-to-back, no loss.
- Flush with 3 pending and wb_valid=1: wb_valid drops next cycle, pending stays 3. Three responses are accepted and dropped with no wb_valid. A new load pushed after the flush returns a correct result.
- Reset asserted mid-stream with 2 pending -> all outputs 0 and pending=0 immediately, without waiting for a clock edge.
